mem_ctrl: RTL and testbench

Memory controller that shares the single byte-wide RAM port between the instruction cache (fetch requester) and the load/store buffer (data requester). It arbitrates, serialises 1/2/4-byte accesses into byte transfers, reassembles read data, and aborts speculative traffic on rollback. It sits between the ICache/LSB and the top-level RAM/IO bus.

---
 rtl/memc_pkg.sv | 30 +++
 rtl/mem_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_mem_ctrl.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memc_pkg.sv
// Shared definitions for mem_ctrl: FSM state codes, ls_size encodings,
// the byte-length helper and the IO address region tag.
package memc_pkg;

   localparam int unsigned BYTE_W = 8;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE     = 2'd0;
   localparam state_t ST_IC_READ  = 2'd1;
   localparam state_t ST_LS_READ  = 2'd2;
   localparam state_t ST_LS_WRITE = 2'd3;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   // addr[17:16] value that marks the UART/IO window
   localparam logic [1:0] IO_REGION = 2'b11;

   function automatic logic [2:0] size_to_len(input logic [1:0] size);
      case (size)
         SZ_BYTE: return 3'd1;
         SZ_HALF: return 3'd2;
         SZ_WORD: return 3'd4;
         default: return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-wide RAM port arbiter/serialiser for ICache fetches and LSB accesses.
// Optional MEMC_IO_GUARD_EN stalls IO-region store bytes while io_buffer_full.
module mem_ctrl
   import memc_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        rollback,
   input  logic        io_buffer_full,
   input  logic        ic_enable,
   input  logic [31:0] ic_addr,
   output logic        ic_valid,
   output logic [31:0] ic_data,
   input  logic        ls_enable,
   input  logic        ls_wr,
   input  logic [1:0]  ls_size,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic        ls_valid,
   output logic [31:0] ls_rdata,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr
);

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        rx_q, rx_d;
   logic [2:0]  len_q, len_d;
   logic [31:0] buf_q, buf_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] mem_a_q, mem_a_d;
   logic [7:0]  mem_dout_q, mem_dout_d;
   logic        mem_wr_q, mem_wr_d;
   logic        ic_valid_q, ic_valid_d;
   logic        ls_valid_q, ls_valid_d;
   logic [31:0] ic_data_q, ic_data_d;
   logic [31:0] ls_rdata_q, ls_rdata_d;
   logic [1:0]  nxt_cnt_c;
   logic        io_stall_c;

   assign nxt_cnt_c = cnt_q + 2'd1;

`ifdef MEMC_IO_GUARD_EN
   // Address of the store byte that would be driven next cycle
   logic [31:0] wr_addr_c;
   always_comb begin
      wr_addr_c = mem_a_q;
      if (state_q == ST_IDLE)
         wr_addr_c = ls_addr;
      else if (mem_wr_q)
         wr_addr_c = mem_a_q + 32'd1;
   end
   assign io_stall_c = io_buffer_full && (wr_addr_c[17:16] == IO_REGION);
`else
   // io_buffer_full has no effect in this build
   assign io_stall_c = io_buffer_full & 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rx_d       = rx_q;
      len_d      = len_q;
      buf_d      = buf_q;
      wdata_d    = wdata_q;
      mem_a_d    = mem_a_q;
      mem_dout_d = mem_dout_q;
      mem_wr_d   = mem_wr_q;
      ic_valid_d = 1'b0;
      ls_valid_d = 1'b0;
      ic_data_d  = ic_data_q;
      ls_rdata_d = ls_rdata_q;

      case (state_q)
         ST_IDLE: begin
            // Valid cycle is the dead cycle; rollback blocks acceptance
            if (!ic_valid_q && !ls_valid_q && !rollback) begin
               if (ls_enable) begin
                  len_d   = size_to_len(ls_size);
                  mem_a_d = ls_addr;
                  cnt_d   = 2'd0;
                  rx_d    = 1'b0;
                  buf_d   = 32'd0;
                  wdata_d = ls_wdata;
                  if (ls_wr) begin
                     state_d    = ST_LS_WRITE;
                     mem_dout_d = ls_wdata[7:0];
                     mem_wr_d   = !io_stall_c;
                  end else begin
                     state_d = ST_LS_READ;
                  end
               end else if (ic_enable) begin
                  state_d = ST_IC_READ;
                  len_d   = 3'd4;
                  mem_a_d = ic_addr;
                  cnt_d   = 2'd0;
                  rx_d    = 1'b0;
                  buf_d   = 32'd0;
               end
            end
         end
         ST_IC_READ, ST_LS_READ: begin
            if (rollback) begin
               state_d  = ST_IDLE;
               mem_wr_d = 1'b0;
            end else if (!rx_q) begin
               rx_d = 1'b1;
               if (len_q > 3'd1)
                  mem_a_d = mem_a_q + 32'd1;
            end else begin
               // mem_din carries byte cnt_q, addressed one cycle earlier
               buf_d[{cnt_q, 3'b000} +: BYTE_W] = mem_din;
               if (3'(cnt_q) + 3'd1 == len_q) begin
                  state_d = ST_IDLE;
                  if (state_q == ST_IC_READ) begin
                     ic_valid_d = 1'b1;
                     ic_data_d  = buf_d;
                  end else begin
                     ls_valid_d = 1'b1;
                     ls_rdata_d = buf_d;
                  end
               end else begin
                  cnt_d = nxt_cnt_c;
                  if (3'(cnt_q) + 3'd2 < len_q)
                     mem_a_d = mem_a_q + 32'd1;
               end
            end
         end
         ST_LS_WRITE: begin
            // Stores are committed: rollback is not looked at here
            if (mem_wr_q) begin
               if (3'(cnt_q) + 3'd1 == len_q) begin
                  state_d    = ST_IDLE;
                  mem_wr_d   = 1'b0;
                  ls_valid_d = 1'b1;
               end else begin
                  cnt_d      = nxt_cnt_c;
                  mem_a_d    = mem_a_q + 32'd1;
                  mem_dout_d = wdata_q[{nxt_cnt_c, 3'b000} +: BYTE_W];
                  mem_wr_d   = !io_stall_c;
               end
            end else begin
               mem_wr_d = !io_stall_c;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 2'd0;
         rx_q       <= 1'b0;
         len_q      <= 3'd0;
         buf_q      <= 32'd0;
         wdata_q    <= 32'd0;
         mem_a_q    <= 32'd0;
         mem_dout_q <= 8'd0;
         mem_wr_q   <= 1'b0;
         ic_valid_q <= 1'b0;
         ls_valid_q <= 1'b0;
         ic_data_q  <= 32'd0;
         ls_rdata_q <= 32'd0;
      end else if (rdy) begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rx_q       <= rx_d;
         len_q      <= len_d;
         buf_q      <= buf_d;
         wdata_q    <= wdata_d;
         mem_a_q    <= mem_a_d;
         mem_dout_q <= mem_dout_d;
         mem_wr_q   <= mem_wr_d;
         ic_valid_q <= ic_valid_d;
         ls_valid_q <= ls_valid_d;
         ic_data_q  <= ic_data_d;
         ls_rdata_q <= ls_rdata_d;
      end
   end

   assign ic_valid = ic_valid_q;
   assign ic_data  = ic_data_q;
   assign ls_valid = ls_valid_q;
   assign ls_rdata = ls_rdata_q;
   assign mem_a    = mem_a_q;
   assign mem_dout = mem_dout_q;
   assign mem_wr   = mem_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: requester tasks push expected results,
// negedge monitors pop them on ic_valid / ls_valid / mem_wr.
module tb_mem_ctrl;

`ifdef MEMC_IO_GUARD_EN
   localparam bit IO_GUARD = 1'b1;
`else
   localparam bit IO_GUARD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, rdy, rollback, io_buffer_full;
   logic        ic_enable, ls_enable, ls_wr;
   logic [1:0]  ls_size;
   logic [31:0] ic_addr, ls_addr, ls_wdata;
   logic        ic_valid, ls_valid, mem_wr;
   logic [31:0] ic_data, ls_rdata, mem_a;
   logic [7:0]  mem_din = 8'd0;
   logic [7:0]  mem_dout;

   mem_ctrl dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
      .io_buffer_full(io_buffer_full),
      .ic_enable(ic_enable), .ic_addr(ic_addr), .ic_valid(ic_valid), .ic_data(ic_data),
      .ls_enable(ls_enable), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
      .ls_wdata(ls_wdata), .ls_valid(ls_valid), .ls_rdata(ls_rdata),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
   );

   always #5 clk = ~clk;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;
   int unsigned cyc = 0;
   int unsigned ic_pulses = 0;
   int unsigned ls_pulses = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Byte-wide RAM: data one cycle after address, frozen while rdy is low
   logic [7:0] ram [0:4095];

   function automatic logic [7:0] ram_init(input int i);
      case (i)
         12'h100: return 8'h13;  12'h101: return 8'h05;
         12'h102: return 8'h00;  12'h103: return 8'h00;
         12'h104: return 8'h93;  12'h105: return 8'h00;
         12'h106: return 8'h10;  12'h107: return 8'h00;
         12'h108: return 8'h37;  12'h109: return 8'h12;
         12'h10A: return 8'h00;  12'h10B: return 8'h00;
         12'h200: return 8'hEF;  12'h201: return 8'hBE;
         12'h202: return 8'hAD;  12'h203: return 8'hDE;
         12'hFFE: return 8'h11;  12'hFFF: return 8'h22;
         12'h000: return 8'h33;  12'h001: return 8'h44;
         default: return 8'(i ^ 8'h5A);
      endcase
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4096; i++) ram[i] <= ram_init(i);
      end else if (rdy) begin
         if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
         mem_din <= ram[mem_a[11:0]];
      end
   end

   typedef struct {
      logic [31:0] data;
      bit          chk_data;
      int unsigned start;
      int unsigned lat;
   } rd_exp_t;

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  data;
   } wr_exp_t;

   rd_exp_t ic_q[$];
   rd_exp_t ls_q[$];
   wr_exp_t wr_q[$];

   always @(negedge clk) begin : monitor
      rd_exp_t e;
      wr_exp_t w;
      if (!rst) begin
         if (ic_valid) begin
            ic_pulses++;
            if (ic_q.size() == 0) chk("ic_valid_unexpected", 32'd1, 32'd0);
            else begin
               e = ic_q.pop_front();
               chk("ic_data", ic_data, e.data);
               chk("ic_latency", cyc - e.start, e.lat);
            end
         end
         if (ls_valid) begin
            ls_pulses++;
            if (ls_q.size() == 0) chk("ls_valid_unexpected", 32'd1, 32'd0);
            else begin
               e = ls_q.pop_front();
               if (e.chk_data) chk("ls_rdata", ls_rdata, e.data);
               chk("ls_latency", cyc - e.start, e.lat);
            end
         end
         if (rdy && mem_wr) begin
            if (wr_q.size() == 0) chk("mem_wr_unexpected", 32'd1, 32'd0);
            else begin
               w = wr_q.pop_front();
               chk("wr_addr", mem_a, w.addr);
               chk("wr_data", {24'd0, mem_dout}, {24'd0, w.data});
            end
         end
      end
   end

   task automatic ls_req(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp, input int unsigned lat);
      rd_exp_t     e;
      wr_exp_t     w;
      int unsigned n;
      int unsigned waited;
      @(negedge clk);
      n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      if (wr) begin
         for (int i = 0; i < int'(n); i++) begin
            w.addr = addr + 32'(i);
            w.data = wdata[8*i +: 8];
            wr_q.push_back(w);
         end
      end
      e.data = exp; e.chk_data = !wr; e.start = cyc; e.lat = lat;
      ls_q.push_back(e);
      ls_wr = wr; ls_size = size; ls_addr = addr; ls_wdata = wdata; ls_enable = 1'b1;
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (!ls_valid && waited < 40);
      if (!ls_valid) chk("ls_timeout", 32'd0, 32'd1);
      ls_enable = 1'b0;
   endtask

   task automatic ic_req(input logic [31:0] addr, input logic [31:0] exp, input int unsigned lat);
      rd_exp_t     e;
      int unsigned waited;
      @(negedge clk);
      e.data = exp; e.chk_data = 1'b1; e.start = cyc; e.lat = lat;
      ic_q.push_back(e);
      ic_addr = addr; ic_enable = 1'b1;
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (!ic_valid && waited < 40);
      if (!ic_valid) chk("ic_timeout", 32'd0, 32'd1);
      ic_enable = 1'b0;
   endtask

   int unsigned p0;

   initial begin
      rst = 1'b1; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
      ic_enable = 1'b0; ic_addr = 32'd0;
      ls_enable = 1'b0; ls_wr = 1'b0; ls_size = 2'd0; ls_addr = 32'd0; ls_wdata = 32'd0;
      repeat (3) @(negedge clk);
      chk("rst_mem_a", mem_a, 32'd0);
      chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
      chk("rst_ic_valid", {31'd0, ic_valid}, 32'd0);
      chk("rst_ls_valid", {31'd0, ls_valid}, 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Word fetch, then a quiet window to catch any re-issue
      p0 = ic_pulses;
      ic_req(32'h100, 32'h0000_0513, 6);
      repeat (8) @(negedge clk);
      chk("fetch_pulse_count", ic_pulses - p0, 32'd1);

      ls_req(1'b0, 2'd0, 32'h201, 32'd0, 32'h0000_00BE, 3);
      ls_req(1'b0, 2'd1, 32'h202, 32'd0, 32'h0000_DEAD, 4);

      // Contention: LSB word load wins, fetch follows after the dead cycle
      fork
         ls_req(1'b0, 2'd2, 32'h200, 32'd0, 32'hDEAD_BEEF, 6);
         ic_req(32'h104, 32'h0010_0093, 13);
      join

      // Half store across a 1 KiB boundary, then read the bytes back
      ls_req(1'b1, 2'd1, 32'h3FF, 32'hAABB_CCDD, 32'd0, 3);
      ls_req(1'b0, 2'd0, 32'h400, 32'd0, 32'h0000_00CC, 3);
      ls_req(1'b0, 2'd0, 32'h3FF, 32'd0, 32'h0000_00DD, 3);

      // Address wraps past 0xFFFFFFFF
      ls_req(1'b0, 2'd2, 32'hFFFF_FFFE, 32'd0, 32'h4433_2211, 6);

      // Rollback at T+3 of a fetch aborts it
      @(negedge clk);
      p0 = ic_pulses;
      ic_addr = 32'h100; ic_enable = 1'b1;
      repeat (3) @(negedge clk);
      rollback = 1'b1; ic_enable = 1'b0;
      @(negedge clk);
      rollback = 1'b0;
      repeat (10) @(negedge clk);
      chk("rb_fetch_no_valid", ic_pulses - p0, 32'd0);

      // Same rollback during a word store: store completes
      fork
         ls_req(1'b1, 2'd2, 32'h500, 32'h1122_3344, 32'd0, 5);
         begin
            @(negedge clk);
            repeat (3) @(negedge clk);
            rollback = 1'b1;
            @(negedge clk);
            rollback = 1'b0;
         end
      join
      ls_req(1'b0, 2'd2, 32'h500, 32'd0, 32'h1122_3344, 6);

      // IO store with io_buffer_full high for three cycles
      fork
         ls_req(1'b1, 2'd0, 32'h0003_0000, 32'h0000_00A5, 32'd0, IO_GUARD ? 5 : 2);
         begin
            @(negedge clk);
            io_buffer_full = 1'b1;
            for (int i = 1; i <= 3; i++) begin
               @(negedge clk);
               chk("io_mem_wr", {31'd0, mem_wr}, {31'd0, (!IO_GUARD && i == 1)});
            end
            io_buffer_full = 1'b0;
         end
      join

      // rdy low for two cycles mid-fetch delays ic_valid by two
      fork
         ic_req(32'h108, 32'h0000_1237, 8);
         begin
            @(negedge clk);
            repeat (2) @(negedge clk);
            rdy = 1'b0;
            repeat (2) @(negedge clk);
            rdy = 1'b1;
         end
      join

      // Reset during LS_READ
      @(negedge clk);
      p0 = ls_pulses;
      ls_wr = 1'b0; ls_size = 2'd2; ls_addr = 32'h200; ls_enable = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b1; ls_enable = 1'b0;
      @(negedge clk);
      chk("rst_mid_mem_a", mem_a, 32'd0);
      chk("rst_mid_mem_dout", {24'd0, mem_dout}, 32'd0);
      chk("rst_mid_mem_wr", {31'd0, mem_wr}, 32'd0);
      chk("rst_mid_ic_data", ic_data, 32'd0);
      chk("rst_mid_ls_rdata", ls_rdata, 32'd0);
      chk("rst_mid_ls_valid", {31'd0, ls_valid}, 32'd0);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("rst_mid_no_valid", ls_pulses - p0, 32'd0);

      chk("ic_queue_empty", 32'(ic_q.size()), 32'd0);
      chk("ls_queue_empty", 32'(ls_q.size()), 32'd0);
      chk("wr_queue_empty", 32'(wr_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
